// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle ARM datapath: sequencing, NZCV flags, condition check, ALU decode.
// Optional MEM_HANDSHAKE_EN macro adds a memory_ready input that stalls FETCH/MEMREAD/MEMWRITE.
module multicycle_controller #(
  parameter int unsigned ALU_CONTROL_WIDTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [19:0]                  instruction,
  input  logic [3:0]                   alu_flags,
`ifdef MEM_HANDSHAKE_EN
  input  logic                         memory_ready,
`endif
  output logic                         pc_write,
  output logic                         address_source,
  output logic                         ir_write,
  output logic                         memory_write,
  output logic                         register_write,
  output logic [1:0]                   result_source,
  output logic                         alu_source_a,
  output logic [1:0]                   alu_source_b,
  output logic [1:0]                   immediate_source,
  output logic [1:0]                   register_source,
  output logic [ALU_CONTROL_WIDTH-1:0] alu_control,
  output logic [3:0]                   state
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_SEL_W = 3;
  localparam bit WIDE_ALU = (ALU_CONTROL_WIDTH == 32'd3);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t state_q, state_d, dec_state;
  logic [3:0] flags_q;
  logic       cond_hold_q;
  logic       ready;

  // Instruction fields, offset by 12 because only IR[31:12] is presented.
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       rd_is_pc;
  logic       unused_rn;

  assign cond      = instruction[19:16];
  assign op        = instruction[15:14];
  assign funct     = instruction[13:8];
  assign cmd       = funct[4:1];
  assign rd        = instruction[3:0];
  assign rd_is_pc  = (rd == 4'hF);
  assign unused_rn = ^instruction[7:4];

`ifdef MEM_HANDSHAKE_EN
  assign ready = memory_ready;
`else
  assign ready = 1'b1;
`endif

  assign state            = state_q;
  assign immediate_source = op;
  assign register_source  = {op == 2'b01, op == 2'b10};

  // Condition check against the stored NZCV.
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_live;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  always_comb begin
    cond_live = 1'b0;
    case (cond)
      4'h0:    cond_live = flag_z;
      4'h1:    cond_live = !flag_z;
      4'h2:    cond_live = flag_c;
      4'h3:    cond_live = !flag_c;
      4'h4:    cond_live = flag_n;
      4'h5:    cond_live = !flag_n;
      4'h6:    cond_live = flag_v;
      4'h7:    cond_live = !flag_v;
      4'h8:    cond_live = flag_c && !flag_z;
      4'h9:    cond_live = !flag_c || flag_z;
      4'hA:    cond_live = (flag_n == flag_v);
      4'hB:    cond_live = (flag_n != flag_v);
      4'hC:    cond_live = !flag_z && (flag_n == flag_v);
      4'hD:    cond_live = flag_z || (flag_n != flag_v);
      4'hE:    cond_live = 1'b1;
      default: cond_live = 1'b0;
    endcase
  end

  // Data-processing command decode.
  logic [ALU_SEL_W-1:0] alu_op;
  logic                 write_allowed;
  logic                 cmd_known;
  logic                 cmd_arith;
  logic                 cmd_compare;

  always_comb begin
    alu_op        = 3'd0;
    write_allowed = 1'b0;
    cmd_known     = 1'b0;
    cmd_arith     = 1'b0;
    cmd_compare   = 1'b0;
    case (cmd)
      4'b0100: begin alu_op = 3'd0; write_allowed = 1'b1; cmd_known = 1'b1; cmd_arith = 1'b1; end
      4'b0010: begin alu_op = 3'd1; write_allowed = 1'b1; cmd_known = 1'b1; cmd_arith = 1'b1; end
      4'b0000: begin alu_op = 3'd2; write_allowed = 1'b1; cmd_known = 1'b1; end
      4'b1100: begin alu_op = 3'd3; write_allowed = 1'b1; cmd_known = 1'b1; end
      4'b0001: if (WIDE_ALU) begin
        alu_op = 3'd4; write_allowed = 1'b1; cmd_known = 1'b1;
      end
      4'b1010: if (WIDE_ALU) begin
        alu_op = 3'd1; cmd_known = 1'b1; cmd_arith = 1'b1; cmd_compare = 1'b1;
      end
      4'b1000: if (WIDE_ALU) begin
        alu_op = 3'd2; cmd_known = 1'b1; cmd_compare = 1'b1;
      end
      default: ;
    endcase
  end

  logic executing;
  logic flag_nz_en;
  logic flag_cv_en;

  assign executing  = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);
  assign flag_nz_en = executing && cond_live && cmd_known && (funct[0] || cmd_compare);
  assign flag_cv_en = flag_nz_en && cmd_arith;

  // Flags and the pre-execute condition result used by ALUWB.
  always_ff @(posedge clock) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      cond_hold_q <= 1'b0;
    end else begin
      if (flag_nz_en) flags_q[3:2] <= alu_flags[3:2];
      if (flag_cv_en) flags_q[1:0] <= alu_flags[1:0];
      if (executing)  cond_hold_q  <= cond_live;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state and control decode; reset forces FETCH decode with enables held low.
  logic [ALU_SEL_W-1:0] alu_sel;

  always_comb begin
    state_d        = S_FETCH;
    pc_write       = 1'b0;
    address_source = 1'b0;
    ir_write       = 1'b0;
    memory_write   = 1'b0;
    register_write = 1'b0;
    result_source  = 2'b00;
    alu_source_a   = 1'b0;
    alu_source_b   = 2'b00;
    alu_sel        = 3'd0;
    dec_state      = reset ? S_FETCH : state_q;
    case (dec_state)
      S_FETCH: begin
        ir_write      = ready;
        pc_write      = ready;
        alu_source_a  = 1'b1;
        alu_source_b  = 2'b10;
        result_source = 2'b10;
        state_d       = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_source_a  = 1'b1;
        alu_source_b  = 2'b10;
        result_source = 2'b10;
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_source_b = 2'b01;
        state_d      = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        address_source = 1'b1;
        state_d        = ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_source  = 2'b01;
        register_write = cond_live;
        pc_write       = cond_live && rd_is_pc;
      end
      S_MEMWRITE: begin
        address_source = 1'b1;
        memory_write   = cond_live;
        state_d        = ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_sel = alu_op;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_source_b = 2'b01;
        alu_sel      = alu_op;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        register_write = cond_hold_q && write_allowed;
        pc_write       = cond_hold_q && write_allowed && rd_is_pc;
      end
      S_BRANCH: begin
        alu_source_b  = 2'b01;
        result_source = 2'b10;
        pc_write      = cond_live;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      pc_write       = 1'b0;
      ir_write       = 1'b0;
      memory_write   = 1'b0;
      register_write = 1'b0;
    end
  end

  if (WIDE_ALU) begin : g_alu_wide
    assign alu_control = alu_sel;
  end else begin : g_alu_narrow
    logic unused_alu_bit;
    assign unused_alu_bit = alu_sel[2];
    assign alu_control    = alu_sel[1:0];
  end

endmodule
